// File: rtl/mdio_peripheral_receiver.sv
// PHY-side MDIO target: deserialises 32-bit management frames from an oversampled MDC/MDIO
// stream into register-file strobes, and serialises read data back onto mdio_in.
module mdio_peripheral_receiver #(
   parameter logic [4:0] PHY_ADDR = 5'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdc,
   input  logic        mdio_out,
   input  logic        mdio_oe,
   output logic        mdio_in,
   output logic [4:0]  reg_addr,
   output logic [15:0] wr_data,
   output logic        wr_stb,
   output logic        rd_stb,
   input  logic [15:0] rd_data,
   output logic        frame_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_WR_DATA,
      S_RD_WAIT,
      S_RD_DATA,
      S_DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic        mdc_q;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] sh_q, sh_d;
   logic        mdio_in_q, mdio_in_d;
   logic [4:0]  reg_addr_q, reg_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        wr_stb_q, wr_stb_d;
   logic        rd_stb_q, rd_stb_d;
   logic        frame_err_q, frame_err_d;

   logic        rise;
   logic [15:0] sh_in;

   assign rise  = mdc & ~mdc_q;
   assign sh_in = {sh_q[14:0], mdio_out};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      sh_d        = sh_q;
      mdio_in_d   = 1'b0;
      reg_addr_d  = reg_addr_q;
      wr_data_d   = wr_data_q;
      wr_stb_d    = 1'b0;
      rd_stb_d    = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rise && mdio_oe) begin
               sh_d      = sh_in;
               bit_cnt_d = 6'd1;
               state_d   = S_HEADER;
            end
         end

         S_HEADER: begin
            if (rise) begin
               if (!mdio_oe) begin
                  frame_err_d = 1'b1;
                  bit_cnt_d   = 6'd0;
                  state_d     = S_IDLE;
               end else begin
                  sh_d      = sh_in;
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  // sh_in now holds ST, OP, PHYAD, REGAD, TA (frame bits 31..16)
                  if (bit_cnt_q == 6'd15) begin
                     if (sh_in[15:14] != 2'b01 ||
                         (sh_in[13:12] != 2'b10 && sh_in[13:12] != 2'b01)) begin
                        frame_err_d = 1'b1;
                        state_d     = S_DRAIN;
                     end else if (sh_in[11:7] != PHY_ADDR) begin
                        state_d = S_DRAIN;
                     end else if (sh_in[13:12] == 2'b10) begin
                        reg_addr_d = sh_in[6:2];
                        rd_stb_d   = 1'b1;
                        state_d    = S_RD_WAIT;
                     end else if (sh_in[1:0] != 2'b10) begin
                        frame_err_d = 1'b1;
                        state_d     = S_DRAIN;
                     end else begin
                        reg_addr_d = sh_in[6:2];
                        state_d    = S_WR_DATA;
                     end
                  end
               end
            end
         end

         S_WR_DATA: begin
            if (rise) begin
               if (!mdio_oe) begin
                  frame_err_d = 1'b1;
                  bit_cnt_d   = 6'd0;
                  state_d     = S_IDLE;
               end else begin
                  sh_d      = sh_in;
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd31) begin
                     wr_data_d = sh_in;
                     wr_stb_d  = 1'b1;
                     bit_cnt_d = 6'd0;
                     state_d   = S_IDLE;
                  end
               end
            end
         end

         // rd_data is valid on the edge right after the rd_stb cycle
         S_RD_WAIT: begin
            sh_d      = rd_data;
            mdio_in_d = rd_data[15];
            state_d   = S_RD_DATA;
         end

         S_RD_DATA: begin
            mdio_in_d = mdio_in_q;
            if (rise) begin
               sh_d      = {sh_q[14:0], 1'b0};
               mdio_in_d = sh_q[14];
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd31) begin
                  mdio_in_d = 1'b0;
                  bit_cnt_d = 6'd0;
                  state_d   = S_IDLE;
               end
            end
         end

         S_DRAIN: begin
            if (rise) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd31) begin
                  bit_cnt_d = 6'd0;
                  state_d   = S_IDLE;
               end
            end
         end

         default: begin
            bit_cnt_d = 6'd0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         mdc_q       <= 1'b0;
         bit_cnt_q   <= 6'd0;
         sh_q        <= 16'd0;
         mdio_in_q   <= 1'b0;
         reg_addr_q  <= 5'd0;
         wr_data_q   <= 16'd0;
         wr_stb_q    <= 1'b0;
         rd_stb_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mdc_q       <= mdc;
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         mdio_in_q   <= mdio_in_d;
         reg_addr_q  <= reg_addr_d;
         wr_data_q   <= wr_data_d;
         wr_stb_q    <= wr_stb_d;
         rd_stb_q    <= rd_stb_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign mdio_in   = mdio_in_q;
   assign reg_addr  = reg_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_stb    = wr_stb_q;
   assign rd_stb    = rd_stb_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_peripheral_receiver.sv
// Bench for mdio_peripheral_receiver: a frame-level generator model predicts strobes, latched
// fields and read-back data; a per-cycle monitor compares the DUT against those predictions.
module tb_mdio_peripheral_receiver;

   localparam logic [4:0] TB_PHY = 5'd0;
   localparam int EV_NONE  = 0;
   localparam int EV_WR    = 1;
   localparam int EV_RD    = 2;
   localparam int EV_ERR   = 3;
   localparam int EV_LATCH = 4;
   localparam int BIG      = 32'h7fff_ffff;

   logic        clk;
   logic        reset;
   logic        mdc;
   logic        mdio_out;
   logic        mdio_oe;
   logic        mdio_in;
   logic [4:0]  reg_addr;
   logic [15:0] wr_data;
   logic        wr_stb;
   logic        rd_stb;
   logic [15:0] rd_data;
   logic        frame_err;

   mdio_peripheral_receiver #(.PHY_ADDR(TB_PHY)) dut (
      .clk       (clk),
      .reset     (reset),
      .mdc       (mdc),
      .mdio_out  (mdio_out),
      .mdio_oe   (mdio_oe),
      .mdio_in   (mdio_in),
      .reg_addr  (reg_addr),
      .wr_data   (wr_data),
      .wr_stb    (wr_stb),
      .rd_stb    (rd_stb),
      .rd_data   (rd_data),
      .frame_err (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_wr = 0, n_rd = 0, n_err = 0;
   int rd_from = 0, rd_to = -1;

   // expected per-cycle events, keyed by monitor cycle number
   int          exp_kind [int];
   logic [4:0]  exp_addr [int];
   logic [15:0] exp_data [int];

   logic [15:0] mem [0:31];
   logic [4:0]  model_addr = '0;
   logic [15:0] model_wdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] mk_frame(input logic [1:0] st, input logic [1:0] op,
                                            input logic [4:0] phy, input logic [4:0] ra,
                                            input logic [1:0] ta, input logic [15:0] d);
      return {st, op, phy, ra, ta, d};
   endfunction

   // Frame-level outcome: up to two events, at rise number b0 and b1
   function automatic void predict(input logic [31:0] f, input int n_oe,
                                   output int b0, output int k0, output int b1, output int k1);
      logic [1:0] st, op, ta;
      logic [4:0] phy;
      st = f[31:30]; op = f[29:28]; phy = f[27:23]; ta = f[17:16];
      b0 = 0; k0 = EV_NONE; b1 = 0; k1 = EV_NONE;
      if (n_oe == 0) return;
      if (n_oe < 16) begin
         b0 = n_oe + 1; k0 = EV_ERR;
         return;
      end
      b0 = 16;
      if (st != 2'b01 || !(op == 2'b10 || op == 2'b01)) k0 = EV_ERR;
      else if (phy != TB_PHY) k0 = EV_NONE;
      else if (op == 2'b10) k0 = EV_RD;
      else if (ta != 2'b10) k0 = EV_ERR;
      else begin
         k0 = EV_LATCH;
         b1 = (n_oe >= 32) ? 32 : n_oe + 1;
         k1 = (n_oe >= 32) ? EV_WR : EV_ERR;
      end
   endfunction

   // Per-cycle monitor: strobes, held fields and idle mdio_in against the model
   initial begin
      int k;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         k = EV_NONE;
         if (exp_kind.exists(cyc)) begin
            k = exp_kind[cyc];
            if (k == EV_WR) begin
               model_addr  = exp_addr[cyc];
               model_wdata = exp_data[cyc];
               mem[exp_addr[cyc]] = exp_data[cyc];
            end else if (k == EV_RD || k == EV_LATCH) begin
               model_addr = exp_addr[cyc];
            end
            exp_kind.delete(cyc);
         end
         if (wr_stb) n_wr++;
         if (rd_stb) n_rd++;
         if (frame_err) n_err++;
         chk("wr_stb", wr_stb, (k == EV_WR));
         chk("rd_stb", rd_stb, (k == EV_RD));
         chk("frame_err", frame_err, (k == EV_ERR));
         chk("reg_addr", reg_addr, model_addr);
         chk("wr_data", wr_data, model_wdata);
         if (!(cyc >= rd_from && cyc <= rd_to)) chk("mdio_in_idle", mdio_in, 1'b0);
         rd_data = (k == EV_RD) ? mem[model_addr] : 16'($urandom);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Generator model: drives one frame; returns bits sampled on rises 17..32 of a read
   task automatic send_frame(input logic [31:0] f, input int n_oe, input int rst_at,
                             output logic [15:0] word);
      int b0, k0, b1, k1, h, c;
      bit is_rd, tail_rand;
      logic oe_v [1:32];
      word = '0;
      predict(f, n_oe, b0, k0, b1, k1);
      is_rd = (k0 == EV_RD);
      tail_rand = (n_oe >= 16) && (k0 != EV_LATCH);
      for (int k = 1; k <= 32; k++)
         oe_v[k] = (k <= n_oe) ? 1'b1 : (tail_rand ? 1'($urandom_range(0, 1)) : 1'b0);
      for (int k = 1; k <= 32; k++) begin
         mdio_out = f[32-k];
         mdio_oe  = oe_v[k];
         h = $urandom_range(1, 3);
         repeat (h) @(negedge clk);
         if (k == rst_at) begin
            reset = 1'b0;
            #1;
            chk("rst_mdio_in", mdio_in, 1'b0);
            model_addr  = '0;
            model_wdata = '0;
            rd_to   = cyc;
            mdio_oe = 1'b0;
            repeat (3) @(negedge clk);
            reset = 1'b1;
            return;
         end
         if (is_rd && k >= 17) word[32-k] = mdio_in;
         mdc = 1'b1;
         c = cyc;
         if (k == b0 && k0 != EV_NONE) begin
            exp_kind[c+1] = k0; exp_addr[c+1] = f[22:18]; exp_data[c+1] = f[15:0];
         end
         if (k == b1 && k1 != EV_NONE) begin
            exp_kind[c+1] = k1; exp_addr[c+1] = f[22:18]; exp_data[c+1] = f[15:0];
         end
         if (is_rd && k == 16) begin rd_from = c + 2; rd_to = BIG; end
         if (is_rd && k == 32) rd_to = c;
         h = $urandom_range(1, 3);
         repeat (h) @(negedge clk);
         mdc = 1'b0;
      end
      mdio_oe = 1'b0;
      if (is_rd && rst_at == 0) begin
         chk("rd_word", word, mem[f[22:18]]);
         $display("read  frame %08h reg %0d word %04h", f, f[22:18], word);
      end else begin
         $display("frame %08h n_oe %0d events %0d/%0d", f, n_oe, k0, k1);
      end
   endtask

   task automatic gap();
      mdio_oe  = 1'b0;
      mdio_out = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 4)) @(negedge clk);
   endtask

   initial begin
      logic [15:0] w;
      logic [31:0] f;
      int w0, r0, e0, sel, n_oe;
      logic [1:0] st, op, ta;
      logic [4:0] phy, ra;

      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      reset = 1'b0; mdc = 1'b0; mdio_out = 1'b0; mdio_oe = 1'b0; rd_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_mdio_in0", mdio_in, 1'b0);
      chk("rst_reg_addr", reg_addr, 5'd0);
      chk("rst_wr_data", wr_data, 16'd0);
      chk("rst_strobes", {wr_stb, rd_stb, frame_err}, 3'b000);
      reset = 1'b1;
      gap();

      // Directed write: reg 2 <- A5A5
      w0 = n_wr; e0 = n_err;
      f = mk_frame(2'b01, 2'b01, 5'd0, 5'h02, 2'b10, 16'hA5A5);
      chk("dir_wr_frame", f, 32'h500A_A5A5);
      send_frame(f, 32, 0, w); gap();
      chk("dir_wr_cnt", n_wr - w0, 1);
      chk("dir_wr_err", n_err - e0, 0);
      chk("dir_wr_addr", reg_addr, 5'h02);
      chk("dir_wr_data", wr_data, 16'hA5A5);

      // Directed read: reg 0 holds BEEF
      mem[0] = 16'hBEEF; r0 = n_rd;
      send_frame(mk_frame(2'b01, 2'b10, 5'd0, 5'd0, 2'b00, 16'h0), 16, 0, w); gap();
      chk("dir_rd_cnt", n_rd - r0, 1);
      chk("dir_rd_word", w, 16'hBEEF);
      chk("dir_rd_addr", reg_addr, 5'd0);

      // Foreign PHY address, then a valid frame
      w0 = n_wr; r0 = n_rd; e0 = n_err;
      send_frame(mk_frame(2'b01, 2'b01, 5'd1, 5'h07, 2'b10, 16'h1234), 32, 0, w); gap();
      chk("phy_skip_cnt", (n_wr - w0) + (n_rd - r0) + (n_err - e0), 0);
      send_frame(mk_frame(2'b01, 2'b01, 5'd0, 5'h07, 2'b10, 16'h1234), 32, 0, w); gap();
      chk("phy_next_wr", n_wr - w0, 1);
      chk("phy_next_data", wr_data, 16'h1234);

      // Bad ST, bad OP
      w0 = n_wr; r0 = n_rd; e0 = n_err;
      send_frame(mk_frame(2'b00, 2'b01, 5'd0, 5'h03, 2'b10, 16'hFFFF), 32, 0, w); gap();
      send_frame(mk_frame(2'b01, 2'b11, 5'd0, 5'h03, 2'b10, 16'hFFFF), 32, 0, w); gap();
      chk("bad_hdr_err", n_err - e0, 2);
      chk("bad_hdr_stb", (n_wr - w0) + (n_rd - r0), 0);

      // Write aborted after bit 24
      w0 = n_wr; e0 = n_err;
      send_frame(mk_frame(2'b01, 2'b01, 5'd0, 5'h04, 2'b10, 16'h5555), 24, 0, w); gap();
      chk("abort_err", n_err - e0, 1);
      chk("abort_wr", n_wr - w0, 0);
      chk("abort_addr", reg_addr, 5'h04);

      // Reset in the middle of read data, then a full write
      mem[5] = 16'hFFFF;
      send_frame(mk_frame(2'b01, 2'b10, 5'd0, 5'h05, 2'b00, 16'h0), 16, 25, w); gap();
      chk("post_rst_addr", reg_addr, 5'd0);
      w0 = n_wr;
      send_frame(mk_frame(2'b01, 2'b01, 5'd0, 5'h09, 2'b10, 16'h0F0F), 32, 0, w); gap();
      chk("post_rst_wr", n_wr - w0, 1);
      chk("post_rst_data", wr_data, 16'h0F0F);

      // Randomised frames
      for (int i = 0; i < 150; i++) begin
         sel  = $urandom_range(0, 7);
         st   = 2'b01;
         op   = $urandom_range(0, 1) ? 2'b10 : 2'b01;
         phy  = TB_PHY;
         ra   = 5'($urandom);
         ta   = (op == 2'b10) ? 2'($urandom) : 2'b10;
         n_oe = 32;
         case (sel)
            2: phy = 5'($urandom_range(1, 31));
            3: st = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
            4: op = $urandom_range(0, 1) ? 2'b00 : 2'b11;
            5: begin op = 2'b01; ta = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11); end
            6: begin op = 2'b01; ta = 2'b10; n_oe = $urandom_range(16, 31); end
            7: n_oe = $urandom_range(1, 15);
            default: ;
         endcase
         send_frame(mk_frame(st, op, phy, ra, ta, 16'($urandom)), n_oe, 0, w);
         gap();
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
